// File: rtl/ir_err_compute.sv
// Weighted IR line-sensor error: right sensors add, left sensors subtract, one term per clock,
// then arithmetic scaling and saturation to a signed 11-bit steering error with a one-cycle strobe.
module ir_err_compute #(
  parameter int SHIFT = 3,
  parameter int ACC_W = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        err_strt,
  input  logic [11:0] IR_R0,
  input  logic [11:0] IR_R1,
  input  logic [11:0] IR_R2,
  input  logic [11:0] IR_R3,
  input  logic [11:0] IR_L0,
  input  logic [11:0] IR_L1,
  input  logic [11:0] IR_L2,
  input  logic [11:0] IR_L3,
  output logic        busy,
  output logic [10:0] err_sat,
  output logic        err_vld
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(1023);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(1024);

  state_t                  state_reg;
  logic [2:0]              idx_reg;
  logic signed [ACC_W-1:0] accum_reg;
  logic [10:0]             err_sat_reg;
  logic                    err_vld_reg;
  logic                    busy_reg;

  logic [11:0]             ir [8];
  logic signed [ACC_W-1:0] term [8];
  logic signed [ACC_W-1:0] term_sel;
  logic signed [ACC_W-1:0] accum_next;
  logic signed [ACC_W-1:0] shifted;
  logic [10:0]             sat_next;

  // Index order matches the accumulation sequence: right sensors first, then left.
  assign ir[0] = IR_R0;
  assign ir[1] = IR_R1;
  assign ir[2] = IR_R2;
  assign ir[3] = IR_R3;
  assign ir[4] = IR_L0;
  assign ir[5] = IR_L1;
  assign ir[6] = IR_L2;
  assign ir[7] = IR_L3;

  // Zero-extend before weighting so the shifted reading never loses its top bits.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_term
      assign term[gi] = ACC_W'(ir[gi]) << (gi % 4);
    end
  endgenerate

  assign term_sel   = term[idx_reg];
  assign accum_next = idx_reg[2] ? (accum_reg - term_sel) : (accum_reg + term_sel);
  assign shifted    = accum_reg >>> SHIFT;

  always_comb begin
    sat_next = shifted[10:0];
    if (shifted > SAT_MAX) begin
      sat_next = 11'h3FF;
    end else if (shifted < SAT_MIN) begin
      sat_next = 11'h400;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= 3'd0;
      accum_reg   <= '0;
      err_sat_reg <= 11'd0;
      err_vld_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      err_vld_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (err_strt) begin
            state_reg <= ACCUM;
            idx_reg   <= 3'd0;
            accum_reg <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ACCUM: begin
          accum_reg <= accum_next;
          idx_reg   <= idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          err_sat_reg <= sat_next;
          err_vld_reg <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign err_sat = err_sat_reg;
  assign err_vld = err_vld_reg;

endmodule

// File: tb/tb_ir_err_compute.sv
// Directed bench for ir_err_compute: hand-computed error values, latency, strobe and start handling.
module tb_ir_err_compute;

  logic        clk;
  logic        rst_n;
  logic        err_strt;
  logic [11:0] ir_r0, ir_r1, ir_r2, ir_r3;
  logic [11:0] ir_l0, ir_l1, ir_l2, ir_l3;
  logic        busy;
  logic [10:0] err_sat;
  logic        err_vld;

  int vectors;
  int miscompares;

  ir_err_compute #(.SHIFT(3), .ACC_W(17)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .err_strt(err_strt),
    .IR_R0   (ir_r0),
    .IR_R1   (ir_r1),
    .IR_R2   (ir_r2),
    .IR_R3   (ir_r3),
    .IR_L0   (ir_l0),
    .IR_L1   (ir_l1),
    .IR_L2   (ir_l2),
    .IR_L3   (ir_l3),
    .busy    (busy),
    .err_sat (err_sat),
    .err_vld (err_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("vector %0d %s observed=0x%0h expected=0x%0h", vectors, tag, obs, exp);
  endtask

  task automatic set_ir(input logic [11:0] r, input logic [11:0] l);
    ir_r0 = r; ir_r1 = r; ir_r2 = r; ir_r3 = r;
    ir_l0 = l; ir_l1 = l; ir_l2 = l; ir_l3 = l;
  endtask

  // Entered at a falling edge. Issues one start, optionally re-pulses start at
  // cycles p1/p2 of the run, and checks latency, strobe count, busy span and result.
  task automatic do_run(input string tag, input logic [10:0] exp, input int p1, input int p2);
    int          first_k;
    int          pulses;
    int          busy_cycles;
    logic [10:0] prev;
    logic [10:0] seen;
    first_k     = -1;
    pulses      = 0;
    busy_cycles = 0;
    seen        = 11'h0;
    prev        = err_sat;
    err_strt    = 1'b1;
    @(negedge clk);
    err_strt = 1'b0;
    if (busy) busy_cycles++;
    check({tag, "_hold_prev"}, 32'(err_sat), 32'(prev));
    for (int k = 1; k <= 20; k++) begin
      err_strt = (k == p1 || k == p2);
      @(negedge clk);
      if (busy) busy_cycles++;
      if (err_vld) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          seen    = err_sat;
        end
      end
    end
    err_strt = 1'b0;
    check({tag, "_latency"}, 32'(first_k), 32'd9);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd9);
    check({tag, "_err_sat"}, 32'(seen), 32'(exp));
  endtask

  initial begin
    int          pulses;
    int          pos [4];
    int          unstable;
    logic [10:0] last;
    vectors     = 0;
    miscompares = 0;

    // Reset held two clocks with start asserted
    rst_n    = 1'b0;
    err_strt = 1'b1;
    set_ir(12'h000, 12'h000);
    repeat (2) @(negedge clk);
    check("rst_err_sat", 32'(err_sat), 32'h000);
    check("rst_err_vld", 32'(err_vld), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n    = 1'b1;
    err_strt = 1'b0;
    pulses   = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (err_vld || busy) pulses++;
    end
    check("rst_idle_quiet", 32'(pulses), 32'd0);

    // 256*15 = 3840 >>> 3 = 480
    set_ir(12'h100, 12'h000);
    do_run("right_100", 11'h1E0, -1, -1);
    set_ir(12'h000, 12'h100);
    do_run("left_100", 11'h620, -1, -1);
    set_ir(12'h800, 12'h800);
    do_run("balanced_800", 11'h000, -1, -1);
    // 4095*15 = 61425 >>> 3 = 7678 -> clip high; negative floors to -7679 -> clip low
    set_ir(12'hFFF, 12'h000);
    do_run("right_fff_sat", 11'h3FF, -1, -1);
    set_ir(12'h000, 12'hFFF);
    do_run("left_fff_sat", 11'h400, -1, -1);

    // Starts during a run are ignored
    set_ir(12'h100, 12'h000);
    do_run("ignore_strt", 11'h1E0, 3, 7);

    // Continuous start: strobe every 10 cycles, err_sat stable between strobes
    set_ir(12'h000, 12'h100);
    err_strt = 1'b1;
    pulses   = 0;
    unstable = 0;
    last     = err_sat;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (err_vld) begin
        if (pulses < 4) pos[pulses] = k;
        pulses++;
        last = err_sat;
      end else if (err_sat !== last) begin
        unstable++;
      end
    end
    err_strt = 1'b0;
    check("cont_pulses", 32'(pulses), 32'd3);
    check("cont_spacing_a", 32'(pos[1] - pos[0]), 32'd10);
    check("cont_spacing_b", 32'(pos[2] - pos[1]), 32'd10);
    check("cont_err_sat", 32'(last), 32'h620);
    check("cont_stable", 32'(unstable), 32'd0);
    repeat (12) @(negedge clk);

    // Reset at E5 of a saturating run
    set_ir(12'hFFF, 12'h000);
    err_strt = 1'b1;
    @(negedge clk);
    err_strt = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (err_vld) pulses++;
    end
    check("abort_no_vld", 32'(pulses), 32'd0);
    check("abort_err_sat", 32'(err_sat), 32'h000);
    check("abort_busy", 32'(busy), 32'h0);
    do_run("after_abort", 11'h3FF, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
